logic_unit_pipe: RTL and testbench

Parametrised, registered bitwise logic unit: the generalised successor of the fixed 8-bit NOR cell. Selects one of eight bitwise operations per transaction, accepts operands over a valid/ready handshake, and returns a registered result with a zero flag. An accumulate mode chains results through an internal register. Sits between operand sources and any downstream consumer that may apply backpressure.

---
 rtl/logic_unit_pipe.sv | 89 ++++++++
 tb/tb_logic_unit_pipe.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/logic_unit_pipe.sv
// Registered bitwise logic unit with a valid/ready handshake, zero flag,
// accumulator chaining and a wrapping count of accepted bundles.
module logic_unit_pipe #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic             acc_mode,
  input  logic             acc_clr,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             zero,
  output logic [15:0]      ops_done
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] y_q;
  logic             zero_q;
  logic [WIDTH-1:0] acc_q;
  logic [15:0]      cnt_q;

  logic [WIDTH-1:0] opA;
  logic [WIDTH-1:0] result_d;
  logic             zero_d;
  logic [15:0]      cnt_d;
  logic             accept;

  // The output slot can be refilled in the same cycle it is drained.
  assign in_ready = rst_n & ((state_q == EMPTY) | out_ready);
  assign accept   = in_valid & in_ready;

  always_comb begin
    opA = a;
    if (acc_mode) begin
      opA = acc_clr ? '0 : acc_q;
    end
    result_d = '0;
    case (op)
      3'b000:  result_d = opA & b;
      3'b001:  result_d = opA | b;
      3'b010:  result_d = ~(opA | b);
      3'b011:  result_d = ~(opA & b);
      3'b100:  result_d = opA ^ b;
      3'b101:  result_d = ~(opA ^ b);
      3'b110:  result_d = ~opA;
      default: result_d = b;
    endcase
    zero_d = (result_d == '0);
    cnt_d  = cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      y_q     <= '0;
      zero_q  <= 1'b1;
      acc_q   <= '0;
      cnt_q   <= 16'd0;
    end else if (accept) begin
      state_q <= FULL;
      y_q     <= result_d;
      zero_q  <= zero_d;
      acc_q   <= result_d;
      cnt_q   <= cnt_d;
    end else begin
      // y/zero keep their last value even after the result is drained.
      if (out_ready) begin
        state_q <= EMPTY;
      end
      if (acc_clr) begin
        acc_q <= '0;
      end
    end
  end

  assign out_valid = (state_q == FULL);
  assign y         = y_q;
  assign zero      = zero_q;
  assign ops_done  = cnt_q;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Directed-vector bench for logic_unit_pipe: 8-bit instance for the main
// behaviour, 1- and 32-bit instances for width corners.
module tb_logic_unit_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstN;
  logic        inValid, inReady, accMode, accClr, outValid, outReady, zeroFlag;
  logic [2:0]  opSel;
  logic [7:0]  opA, opB, yOut;
  logic [15:0] opsDone;

  logic        w1Valid, w1Ready, w1OutValid, w1Zero;
  logic [2:0]  w1Op;
  logic [0:0]  w1A, w1B, w1Y;
  logic [15:0] w1Ops;

  logic        w32Valid, w32Ready, w32OutValid, w32Zero;
  logic [2:0]  w32Op;
  logic [31:0] w32A, w32B, w32Y;
  logic [15:0] w32Ops;

  int checkCount = 0;
  int errorCount = 0;

  logic [7:0] sweepExp [8] = '{8'hA0, 8'hFA, 8'h05, 8'h5F, 8'h5A, 8'hA5, 8'h0F, 8'hAA};

  logic_unit_pipe #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rstN), .in_valid(inValid), .in_ready(inReady),
    .op(opSel), .acc_mode(accMode), .acc_clr(accClr), .a(opA), .b(opB),
    .out_valid(outValid), .out_ready(outReady), .y(yOut), .zero(zeroFlag),
    .ops_done(opsDone)
  );

  logic_unit_pipe #(.WIDTH(1)) dutW1 (
    .clk(clk), .rst_n(rstN), .in_valid(w1Valid), .in_ready(w1Ready),
    .op(w1Op), .acc_mode(1'b0), .acc_clr(1'b0), .a(w1A), .b(w1B),
    .out_valid(w1OutValid), .out_ready(1'b1), .y(w1Y), .zero(w1Zero),
    .ops_done(w1Ops)
  );

  logic_unit_pipe #(.WIDTH(32)) dutW32 (
    .clk(clk), .rst_n(rstN), .in_valid(w32Valid), .in_ready(w32Ready),
    .op(w32Op), .acc_mode(1'b0), .acc_clr(1'b0), .a(w32A), .b(w32B),
    .out_valid(w32OutValid), .out_ready(1'b1), .y(w32Y), .zero(w32Zero),
    .ops_done(w32Ops)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [2:0] op, input logic accm,
                               input logic clr, input logic [7:0] a, input logic [7:0] b,
                               input logic ordy);
    inValid  = valid;
    opSel    = op;
    accMode  = accm;
    accClr   = clr;
    opA      = a;
    opB      = b;
    outReady = ordy;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rstN = 1'b0;
    applyStimulus(1'b1, 3'b000, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
    w1Valid = 1'b0;  w1Op = 3'b010;  w1A = 1'b0;  w1B = 1'b0;
    w32Valid = 1'b0; w32Op = 3'b010; w32A = '0;   w32B = '0;
    #1;
    checkOutput("in_ready_in_reset", {31'd0, inReady}, 32'd0);
    step();
    step();
    checkOutput("rst_out_valid", {31'd0, outValid}, 32'd0);
    checkOutput("rst_y", {24'd0, yOut}, 32'h00);
    checkOutput("rst_zero", {31'd0, zeroFlag}, 32'd1);
    checkOutput("rst_ops_done", {16'd0, opsDone}, 32'd0);
    rstN = 1'b1;
    applyStimulus(1'b0, 3'b010, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
    #1;
    checkOutput("in_ready_after_reset", {31'd0, inReady}, 32'd1);

    // Basic NOR
    applyStimulus(1'b1, 3'b010, 1'b0, 1'b0, 8'hF0, 8'h00, 1'b1);
    step();
    checkOutput("nor1_y", {24'd0, yOut}, 32'h0F);
    checkOutput("nor1_zero", {31'd0, zeroFlag}, 32'd0);
    checkOutput("nor1_valid", {31'd0, outValid}, 32'd1);
    applyStimulus(1'b1, 3'b010, 1'b0, 1'b0, 8'hF0, 8'hFF, 1'b1);
    step();
    checkOutput("nor2_y", {24'd0, yOut}, 32'h00);
    checkOutput("nor2_zero", {31'd0, zeroFlag}, 32'd1);
    applyStimulus(1'b1, 3'b010, 1'b0, 1'b0, 8'hF0, 8'hAA, 1'b1);
    step();
    checkOutput("nor3_y", {24'd0, yOut}, 32'h05);
    checkOutput("nor_ops_done", {16'd0, opsDone}, 32'd3);

    // Op sweep
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 3'(i), 1'b0, 1'b0, 8'hF0, 8'hAA, 1'b1);
      step();
      checkOutput($sformatf("sweep_op%0d", i), {24'd0, yOut}, {24'd0, sweepExp[i]});
    end
    checkOutput("sweep_ops_done", {16'd0, opsDone}, 32'd11);

    // Backpressure
    applyStimulus(1'b1, 3'b001, 1'b0, 1'b0, 8'h0F, 8'hF0, 1'b1);
    step();
    checkOutput("bp_first_y", {24'd0, yOut}, 32'hFF);
    applyStimulus(1'b1, 3'b000, 1'b0, 1'b0, 8'hFF, 8'h3C, 1'b0);
    #1;
    checkOutput("bp_in_ready_low", {31'd0, inReady}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      checkOutput($sformatf("bp_hold_y%0d", i), {24'd0, yOut}, 32'hFF);
      checkOutput($sformatf("bp_hold_valid%0d", i), {31'd0, outValid}, 32'd1);
      checkOutput($sformatf("bp_hold_ready%0d", i), {31'd0, inReady}, 32'd0);
    end
    outReady = 1'b1;
    #1;
    checkOutput("bp_release_ready", {31'd0, inReady}, 32'd1);
    step();
    checkOutput("bp_next_y", {24'd0, yOut}, 32'h3C);
    checkOutput("bp_ops_done", {16'd0, opsDone}, 32'd13);

    // Accumulate; the first bundle clears the stale accumulator
    applyStimulus(1'b1, 3'b100, 1'b1, 1'b1, 8'h00, 8'h01, 1'b1);
    step();
    checkOutput("acc_y1", {24'd0, yOut}, 32'h01);
    applyStimulus(1'b1, 3'b100, 1'b1, 1'b0, 8'h00, 8'h02, 1'b1);
    step();
    checkOutput("acc_y2", {24'd0, yOut}, 32'h03);
    applyStimulus(1'b1, 3'b100, 1'b1, 1'b0, 8'h00, 8'h04, 1'b1);
    step();
    checkOutput("acc_y3", {24'd0, yOut}, 32'h07);
    applyStimulus(1'b1, 3'b100, 1'b1, 1'b1, 8'h00, 8'h08, 1'b1);
    step();
    checkOutput("acc_clr_y", {24'd0, yOut}, 32'h08);
    applyStimulus(1'b0, 3'b100, 1'b1, 1'b1, 8'h00, 8'h00, 1'b1);
    step();
    checkOutput("idle_valid_drop", {31'd0, outValid}, 32'd0);
    checkOutput("idle_y_hold", {24'd0, yOut}, 32'h08);
    applyStimulus(1'b1, 3'b100, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1);
    step();
    checkOutput("acc_clr_idle_y", {24'd0, yOut}, 32'h00);
    checkOutput("acc_ops_done", {16'd0, opsDone}, 32'd18);

    // Reset while a result is held under backpressure
    applyStimulus(1'b1, 3'b001, 1'b0, 1'b0, 8'h5A, 8'h00, 1'b1);
    step();
    applyStimulus(1'b0, 3'b001, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    step();
    checkOutput("pre_rst_y", {24'd0, yOut}, 32'h5A);
    rstN = 1'b0;
    applyStimulus(1'b1, 3'b111, 1'b0, 1'b0, 8'h00, 8'h77, 1'b0);
    #1;
    checkOutput("mid_rst_in_ready", {31'd0, inReady}, 32'd0);
    step();
    checkOutput("mid_rst_valid", {31'd0, outValid}, 32'd0);
    checkOutput("mid_rst_y", {24'd0, yOut}, 32'h00);
    checkOutput("mid_rst_zero", {31'd0, zeroFlag}, 32'd1);
    checkOutput("mid_rst_ops", {16'd0, opsDone}, 32'd0);
    rstN = 1'b1;
    applyStimulus(1'b1, 3'b100, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1);
    step();
    checkOutput("post_rst_acc_y", {24'd0, yOut}, 32'h00);
    checkOutput("post_rst_acc_zero", {31'd0, zeroFlag}, 32'd1);

    // Width corners
    inValid = 1'b0;
    w1Valid = 1'b1;  w1A = 1'b1;  w1B = 1'b0;
    w32Valid = 1'b1; w32A = 32'hFFFF_FFFF; w32B = 32'h0;
    step();
    checkOutput("w1_y", {31'd0, w1Y}, 32'd0);
    checkOutput("w1_zero", {31'd0, w1Zero}, 32'd1);
    checkOutput("w1_valid", {31'd0, w1OutValid}, 32'd1);
    checkOutput("w32_y", w32Y, 32'h0);
    checkOutput("w32_zero", {31'd0, w32Zero}, 32'd1);
    w1A = 1'b0;
    w32A = 32'h0;
    step();
    checkOutput("w1_nor0_y", {31'd0, w1Y}, 32'd1);
    checkOutput("w32_nor0_y", w32Y, 32'hFFFF_FFFF);
    checkOutput("w32_nor0_zero", {31'd0, w32Zero}, 32'd0);
    w1Valid = 1'b0;
    w32Valid = 1'b0;

    // Counter wrap: one accept already counted since reset
    applyStimulus(1'b1, 3'b111, 1'b0, 1'b0, 8'h00, 8'h11, 1'b1);
    for (int i = 0; i < 65534; i++) begin
      step();
    end
    checkOutput("wrap_ffff", {16'd0, opsDone}, 32'h0000_FFFF);
    step();
    checkOutput("wrap_zero", {16'd0, opsDone}, 32'h0);
    inValid = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
